// File: rtl/alu_operand_loader.sv
// Operand entry front-end for a 4-bit ALU: one debounced push button steps through A, B, op capture.
// Define LOADER_STATUS_EN to drive the one-hot status LEDs; otherwise status is tied to zero.
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [3:0] sw,
  input  logic       op_sw,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       sum_notsub,
  output logic       operands_valid,
  output logic [3:0] status
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  logic             key_meta_reg, key_sync_reg;
  logic [3:0]       sw_meta_reg, sw_sync_reg;
  logic             op_meta_reg, op_sync_reg;
  logic             key_db_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             press_reg;

  state_t     state_reg, state_next;
  logic [3:0] a_reg, a_next;
  logic [3:0] b_reg, b_next;
  logic       sn_reg, sn_next;
  logic       valid_reg, valid_next;

  // Key idles released (1) through the synchronizer so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_reg <= 1'b1;
      key_sync_reg <= 1'b1;
      op_meta_reg  <= 1'b0;
      op_sync_reg  <= 1'b0;
    end else begin
      key_meta_reg <= key_n;
      key_sync_reg <= key_meta_reg;
      op_meta_reg  <= op_sw;
      op_sync_reg  <= op_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sw_meta_reg[gi] <= 1'b0;
          sw_sync_reg[gi] <= 1'b0;
        end else begin
          sw_meta_reg[gi] <= sw[gi];
          sw_sync_reg[gi] <= sw_meta_reg[gi];
        end
      end
    end
  endgenerate

  // Counter saturates at CNT_MAX by construction: it is cleared on acceptance or agreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db_reg <= 1'b1;
      cnt_reg    <= '0;
      press_reg  <= 1'b0;
    end else begin
      press_reg <= key_db_reg & ~key_sync_reg & (cnt_reg == CNT_MAX);
      if (key_sync_reg == key_db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        key_db_reg <= key_sync_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_A;
      a_reg     <= '0;
      b_reg     <= '0;
      sn_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sn_reg    <= sn_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sn_next    = sn_reg;
    if (press_reg) begin
      case (state_reg)
        S_A: begin
          a_next     = sw_sync_reg;
          state_next = S_B;
        end
        S_B: begin
          b_next     = sw_sync_reg;
          state_next = S_OP;
        end
        S_OP: begin
          sn_next    = op_sync_reg;
          state_next = S_RUN;
        end
        default: state_next = S_A;
      endcase
    end
    valid_next = (state_next == S_RUN);
  end

  assign A              = a_reg;
  assign B              = b_reg;
  assign sum_notsub     = sn_reg;
  assign operands_valid = valid_reg;

`ifdef LOADER_STATUS_EN
  logic [3:0] status_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_reg <= 4'b0001;
    else        status_reg <= 4'b0001 << state_next;
  end

  assign status = status_reg;
`else
  assign status = 4'b0000;
`endif

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning cycles key_n must be stable before accepted (legal >= 2).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port key_n  input  1  raw push button, low = pressed, asynchronous, bouncy.
REQ-005 SHALL have port sw  input  4  operand switches, quasi-static.
REQ-006 SHALL have port op_sw  input  1  operation switch, 1 = add, 0 = subtract.
REQ-007 SHALL have port A  output  4  captured operand A, feeds ALU A.
REQ-008 SHALL have port B  output  4  captured operand B, feeds ALU B.
REQ-009 SHALL have port sum_notsub  output  1  captured operation, feeds ALU sum_notsub.
REQ-010 SHALL have port operands_valid  output  1  high when A, B, sum_notsub form a complete entry.
REQ-011 SHALL have port status  output  4  one-hot state indicator for LEDs.

Function
REQ-012 SHALL pass key_n, sw, op_sw each through a 2-flop synchronizer before any use.
REQ-013 SHALL debounce synced key_n: counter cleared whenever synced value equals debounced value; else increments; debounced value takes synced value when counter reaches DEBOUNCE_CYCLES-1.
REQ-014 SHALL use counter width ceil(log2(DEBOUNCE_CYCLES)); counter SHALL never wrap.
REQ-015 SHALL generate press, a 1-cycle pulse, only on debounced 1->0 transition; release generates nothing.
REQ-016 SHALL ignore any key_n pulse/bounce stable for fewer than DEBOUNCE_CYCLES cycles.
REQ-017 SHALL hold exactly one press per physical press regardless of hold duration.
REQ-018 SHALL implement FSM states S_A, S_B, S_OP, S_RUN; transitions only on press.
REQ-019 S_A + press: A <= synced sw; next S_B.
REQ-020 S_B + press: B <= synced sw; next S_OP.
REQ-021 S_OP + press: sum_notsub <= synced op_sw; next S_RUN.
REQ-022 S_RUN + press: next S_A; A, B, sum_notsub retained until overwritten.
REQ-023 SHALL register all outputs; captured value and new state visible the cycle after press.
REQ-024 operands_valid SHALL be high exactly while in S_RUN.
REQ-025 sw/op_sw changes without press SHALL NOT alter A, B, sum_notsub.
REQ-026 Latency from stable key_n fall to output update SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles (+/-1).

Reset
REQ-027 rst_n low SHALL immediately force A=0, B=0, sum_notsub=0, operands_valid=0, state S_A, counter 0, debounced key = released (1), synchronizers = released/0.
REQ-028 Reset asserted mid-debounce or mid-entry SHALL discard partial entry; no press pulse SHALL follow deassertion unless key held through a full new debounce window.
REQ-029 status SHALL read 4'b0001 (or 4'b0000 per REQ-031) during reset.

Configuration
REQ-030 With LOADER_STATUS_EN defined, status SHALL be one-hot: S_A=0001, S_B=0010, S_OP=0100, S_RUN=1000, registered with state.
REQ-031 Without LOADER_STATUS_EN, status SHALL be constant 4'b0000 and no status logic synthesized; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=8, LOADER_STATUS_EN defined unless noted)
REQ-032 Reset pulse -> A=0, B=0, sum_notsub=0, operands_valid=0, status=0001.
REQ-033 sw=5 clean press, sw=3 clean press, op_sw=0 clean press -> A=5, B=3, sum_notsub=0, operands_valid=1, status=1000.
REQ-034 key_n low pulses of 3 cycles repeated 10 times in S_B -> no capture, status stays 0010.
REQ-035 key_n held low 200 cycles in S_A with sw=9 -> A=9, single advance to S_B only.
REQ-036 press in S_RUN -> operands_valid=0, status=0001, A=5, B=3 unchanged; rst_n pulsed while in S_OP -> all outputs 0 same cycle, status=0001.
REQ-037 Rebuild without LOADER_STATUS_EN, rerun REQ-033 -> identical A/B/valid, status=0000 throughout.
